// File: rtl/hex_entry_to_bin.sv
// ASCII-hex keystroke assembler: shifts hex nibbles into a NUM_DIGITS-digit code,
// handles BS/ESC/ENTER, and hands the completed code off over valid/ready.
module hex_entry_to_bin #(
  parameter int unsigned NUM_DIGITS = 4,
  localparam int unsigned W  = 4 * NUM_DIGITS,
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          char_valid,
  input  logic [7:0]    char_data,
  output logic          char_ready,
  input  logic          clear,
  output logic [W-1:0]  code,
  output logic          code_valid,
  input  logic          code_ready,
  output logic [CW-1:0] digit_count,
  output logic          err_pulse
);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_ENTER = 8'h0D;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_code, w_code_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_err, w_err_nxt;

  logic          w_is_hex;
  logic [3:0]    w_nibble;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;

  always_comb begin
    w_is_hex = 1'b0;
    w_nibble = 4'd0;
    if (char_data >= 8'h30 && char_data <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nibble = char_data[3:0];
    end else if ((char_data >= 8'h41 && char_data <= 8'h46) ||
                 (char_data >= 8'h61 && char_data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 lands on 10
      w_is_hex = 1'b1;
      w_nibble = char_data[3:0] + 4'd9;
    end
  end

  assign char_ready = (r_state == COLLECT);
  assign code_valid = (r_state == HOLD);
  assign w_accept   = char_valid && char_ready;
  assign w_full     = (r_count == CW'(NUM_DIGITS));
  assign w_empty    = (r_count == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_count_nxt = r_count;
    w_err_nxt   = 1'b0;
    if (clear) begin
      w_state_nxt = COLLECT;
      w_code_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            if (w_is_hex) begin
              if (!w_full) begin
                w_code_nxt  = (r_code << 4) | W'(w_nibble);
                w_count_nxt = r_count + 1'b1;
              end else begin
                w_err_nxt = 1'b1;
              end
            end else if (char_data == CH_BS) begin
              if (!w_empty) begin
                w_code_nxt  = r_code >> 4;
                w_count_nxt = r_count - 1'b1;
              end else begin
                w_err_nxt = 1'b1;
              end
            end else if (char_data == CH_ESC) begin
              w_code_nxt  = '0;
              w_count_nxt = '0;
            end else if (char_data == CH_ENTER) begin
              if (w_full) w_state_nxt = HOLD;
              else        w_err_nxt   = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        HOLD: begin
          if (code_ready) begin
            w_state_nxt = COLLECT;
            w_code_nxt  = '0;
            w_count_nxt = '0;
          end
        end
        default: w_state_nxt = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_code  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign code        = r_code;
  assign digit_count = r_count;
  assign err_pulse   = r_err;

endmodule

// File: tb/tb_hex_entry_to_bin.sv
// Directed table-driven bench for hex_entry_to_bin (NUM_DIGITS=4), plus
// hand-written async-reset sequences.
module tb_hex_entry_to_bin;

  logic        clk;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        clear;
  logic [15:0] code;
  logic        code_valid;
  logic        code_ready;
  logic [2:0]  digit_count;
  logic        err_pulse;

  int unsigned errors = 0;
  int unsigned checks = 0;

  hex_entry_to_bin #(.NUM_DIGITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_ready  (char_ready),
    .clear       (clear),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .digit_count (digit_count),
    .err_pulse   (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        clr;
    logic        cr;
    logic [15:0] e_code;
    logic [2:0]  e_cnt;
    logic        e_cv;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic clr, input logic cr,
                     input logic [15:0] ec, input logic [2:0] en, input logic ecv,
                     input logic eerr);
    vec_t t;
    t.v = v; t.d = d; t.clr = clr; t.cr = cr;
    t.e_code = ec; t.e_cnt = en; t.e_cv = ecv; t.e_err = eerr;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".code"}, 32'(code), 32'h0);
    chk({tag, ".count"}, 32'(digit_count), 32'h0);
    chk({tag, ".code_valid"}, 32'(code_valid), 32'h0);
    chk({tag, ".char_ready"}, 32'(char_ready), 32'h1);
    chk({tag, ".err"}, 32'(err_pulse), 32'h0);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    char_valid = 1'b1; char_data = d;
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; char_valid = 1'b0; char_data = 8'h00; clear = 1'b0; code_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    // v, data, clear, code_ready -> code, count, code_valid, err
    add(1, "1",   0, 0, 16'h0001, 1, 0, 0);
    add(1, "a",   0, 0, 16'h001A, 2, 0, 0);
    add(1, "F",   0, 0, 16'h01AF, 3, 0, 0);
    add(1, "3",   0, 0, 16'h1AF3, 4, 0, 0);
    add(1, 8'h0D, 0, 0, 16'h1AF3, 4, 1, 0);
    add(0, 8'h00, 0, 0, 16'h1AF3, 4, 1, 0);
    add(1, "5",   0, 0, 16'h1AF3, 4, 1, 0);  // HOLD: not ready, not consumed
    add(0, 8'h00, 0, 1, 16'h0000, 0, 0, 0);
    add(1, "7",   0, 0, 16'h0007, 1, 0, 0);
    add(1, 8'h0D, 0, 0, 16'h0007, 1, 0, 1);
    add(1, "1",   0, 0, 16'h0071, 2, 0, 0);
    add(1, "2",   0, 0, 16'h0712, 3, 0, 0);
    add(1, "3",   0, 0, 16'h7123, 4, 0, 0);
    add(1, "4",   0, 0, 16'h7123, 4, 0, 1);
    add(1, 8'h1B, 0, 0, 16'h0000, 0, 0, 0);
    add(1, "B",   0, 0, 16'h000B, 1, 0, 0);
    add(1, "C",   0, 0, 16'h00BC, 2, 0, 0);
    add(1, 8'h08, 0, 0, 16'h000B, 1, 0, 0);
    add(1, 8'h08, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 8'h08, 0, 0, 16'h0000, 0, 0, 1);
    add(1, "D",   0, 0, 16'h000D, 1, 0, 0);
    add(1, 8'h1B, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 8'h1B, 0, 0, 16'h0000, 0, 0, 0);  // ESC on empty: no error
    add(1, "E",   0, 0, 16'h000E, 1, 0, 0);
    add(1, "G",   0, 0, 16'h000E, 1, 0, 1);
    add(1, " ",   0, 0, 16'h000E, 1, 0, 1);
    add(1, "g",   0, 0, 16'h000E, 1, 0, 1);
    add(1, "9",   0, 0, 16'h00E9, 2, 0, 0);
    add(1, "9",   0, 0, 16'h0E99, 3, 0, 0);
    add(1, "9",   0, 0, 16'hE999, 4, 0, 0);
    add(1, 8'h1B, 0, 0, 16'h0000, 0, 0, 0);
    add(1, "b",   0, 0, 16'h000B, 1, 0, 0);
    add(1, "E",   0, 0, 16'h00BE, 2, 0, 0);
    add(1, "e",   0, 0, 16'h0BEE, 3, 0, 0);
    add(1, "F",   0, 0, 16'hBEEF, 4, 0, 0);
    add(1, 8'h0D, 0, 0, 16'hBEEF, 4, 1, 0);
    add(0, 8'h00, 1, 1, 16'h0000, 0, 0, 0);  // clear + handshake together
    add(1, "5",   1, 0, 16'h0000, 0, 0, 0);  // clear drops digit
    add(1, "5",   0, 0, 16'h0005, 1, 0, 0);
    add(1, "x",   1, 0, 16'h0000, 0, 0, 0);  // clear suppresses err
    add(1, "@",   0, 0, 16'h0000, 0, 0, 1);
    add(1, 8'h60, 0, 0, 16'h0000, 0, 0, 1);
    add(1, ":",   0, 0, 16'h0000, 0, 0, 1);
    add(1, "/",   0, 0, 16'h0000, 0, 0, 1);
    add(0, "5",   0, 0, 16'h0000, 0, 0, 0);  // no valid: nothing accepted
    add(1, "0",   0, 0, 16'h0000, 1, 0, 0);
    add(1, "A",   0, 0, 16'h000A, 2, 0, 0);
    add(1, "f",   0, 0, 16'h00AF, 3, 0, 0);
    add(1, 8'h1B, 0, 0, 16'h0000, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      char_valid = tbl[i].v; char_data = tbl[i].d;
      clear = tbl[i].clr; code_ready = tbl[i].cr;
      @(posedge clk); #1;
      chk($sformatf("v%0d.code", i), 32'(code), 32'(tbl[i].e_code));
      chk($sformatf("v%0d.count", i), 32'(digit_count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d.code_valid", i), 32'(code_valid), 32'(tbl[i].e_cv));
      chk($sformatf("v%0d.char_ready", i), 32'(char_ready), 32'(!tbl[i].e_cv));
      chk($sformatf("v%0d.err", i), 32'(err_pulse), 32'(tbl[i].e_err));
    end
    @(negedge clk);
    char_valid = 1'b0; clear = 1'b0; code_ready = 1'b0;

    // Async reset mid-entry (count=2)
    send("1");
    send("2");
    chk("pre_rst1.count", 32'(digit_count), 32'h2);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_mid");
    @(negedge clk) rst_n = 1'b1;

    // Async reset in HOLD
    send("C"); send("A"); send("F"); send("E"); send(8'h0D);
    chk("pre_rst2.code", 32'(code), 32'hCAFE);
    chk("pre_rst2.code_valid", 32'(code_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_hold");
    @(negedge clk) rst_n = 1'b1;

    send("4");
    chk("post_rst.code", 32'(code), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
